// File: rtl/gcd_pkg.sv
// ============================================================================
//  Module      : gcd_pkg
//  Description : Shared constants and state encoding for the GCD operand sequencer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

   localparam int c_WIDTH = 16;

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_LOAD_A = 3'd1;
   localparam logic [2:0] c_ST_LOAD_B = 3'd2;
   localparam logic [2:0] c_ST_RUN    = 3'd3;
   localparam logic [2:0] c_ST_CLEAR  = 3'd4;
   localparam logic [2:0] c_ST_RESP   = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = c_ST_IDLE,
      ST_LOAD_A = c_ST_LOAD_A,
      ST_LOAD_B = c_ST_LOAD_B,
      ST_RUN    = c_ST_RUN,
      ST_CLEAR  = c_ST_CLEAR,
      ST_RESP   = c_ST_RESP
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/gcd_watchdog.sv
// ============================================================================
//  Module      : gcd_watchdog
//  Description : Saturating cycle counter that flags an engine that never finishes.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module gcd_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int              c_CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT_CYCLES);
   localparam logic [c_CW-1:0] c_LAST  = c_CW'(TIMEOUT_CYCLES - 1);

   logic [c_CW-1:0] r_count_q;
   logic [c_CW-1:0] w_count_d;

   always_comb begin
      w_count_d = r_count_q;
      if (clear) begin
         w_count_d = '0;
      end else if (enable && (r_count_q != c_LIMIT)) begin
         w_count_d = r_count_q + c_CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count_q <= '0;
      end else begin
         r_count_q <= w_count_d;
      end
   end

   // Fires in the enabled cycle whose increment makes the count reach the limit,
   // so exactly TIMEOUT_CYCLES enabled cycles elapse before expiry.
   assign expired = enable && (r_count_q >= c_LAST);

endmodule

`default_nettype wire

// File: rtl/gcd_operand_sequencer.sv
// ============================================================================
//  Module      : gcd_operand_sequencer
//  Description : Feeds operand pairs to a subtractive GCD engine, returns results.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module gcd_operand_sequencer
   import gcd_pkg::*;
#(
   parameter int WIDTH          = c_WIDTH,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_gcd,
   output logic             rsp_err,
   output logic             gcd_start,
   output logic [WIDTH-1:0] gcd_data_in,
   output logic             gcd_clr,
   input  logic             gcd_done,
   input  logic [WIDTH-1:0] gcd_result
);

   seq_state_t       r_state_q, w_state_d;
   logic [WIDTH-1:0] r_a_q, w_a_d;
   logic [WIDTH-1:0] r_b_q, w_b_d;
   logic [WIDTH-1:0] r_gcd_q, w_gcd_d;
   logic             r_err_q, w_err_d;
   logic             w_wd_clear;
   logic             w_wd_enable;
   logic             w_wd_expired;

   gcd_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_wd_clear),
      .enable  (w_wd_enable),
      .expired (w_wd_expired)
   );

   always_comb begin
      w_state_d   = r_state_q;
      w_a_d       = r_a_q;
      w_b_d       = r_b_q;
      w_gcd_d     = r_gcd_q;
      w_err_d     = r_err_q;
      w_wd_clear  = 1'b0;
      w_wd_enable = 1'b0;
      unique case (r_state_q)
         ST_IDLE: begin
            if (req_valid) begin
               w_a_d = req_a;
               w_b_d = req_b;
               // The subtractive engine never terminates on a zero operand.
               if ((req_a == '0) || (req_b == '0)) begin
                  w_gcd_d   = req_a | req_b;
                  w_err_d   = 1'b0;
                  w_state_d = ST_RESP;
               end else begin
                  w_state_d = ST_LOAD_A;
               end
            end
         end
         ST_LOAD_A: w_state_d = ST_LOAD_B;
         ST_LOAD_B: begin
            w_wd_clear = 1'b1;
            w_state_d  = ST_RUN;
         end
         ST_RUN: begin
            w_wd_enable = 1'b1;
            if (gcd_done) begin
               w_gcd_d   = gcd_result;
               w_err_d   = 1'b0;
               w_state_d = ST_CLEAR;
            end else if (w_wd_expired) begin
               w_gcd_d   = '0;
               w_err_d   = 1'b1;
               w_state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: w_state_d = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_d = ST_IDLE;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= ST_IDLE;
         r_a_q     <= '0;
         r_b_q     <= '0;
         r_gcd_q   <= '0;
         r_err_q   <= 1'b0;
      end else begin
         r_state_q <= w_state_d;
         r_a_q     <= w_a_d;
         r_b_q     <= w_b_d;
         r_gcd_q   <= w_gcd_d;
         r_err_q   <= w_err_d;
      end
   end

   assign req_ready   = ~rst && (r_state_q == ST_IDLE);
   assign rsp_valid   = (r_state_q == ST_RESP);
   assign rsp_gcd     = r_gcd_q;
   assign rsp_err     = r_err_q;
   assign gcd_start   = (r_state_q == ST_LOAD_A);
   assign gcd_clr     = rst || (r_state_q == ST_CLEAR);
   assign gcd_data_in = (r_state_q == ST_LOAD_A) ? r_a_q :
                        ((r_state_q == ST_LOAD_B) || (r_state_q == ST_RUN)) ? r_b_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_gcd_operand_sequencer.sv
// ============================================================================
//  Module      : tb_gcd_operand_sequencer
//  Description : Self-checking bench with a behavioural GCD engine and a hung stub.
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gcd_operand_sequencer;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_err;
   logic         gcd_start, gcd_clr, gcd_done;
   logic [W-1:0] req_a = '0, req_b = '0, rsp_gcd, gcd_data_in, gcd_result;

   logic         t_req_valid = 1'b0, t_req_ready, t_rsp_valid, t_rsp_ready = 1'b1, t_rsp_err;
   logic         t_gcd_start, t_gcd_clr;
   logic [W-1:0] t_req_a = '0, t_req_b = '0, t_rsp_gcd, t_gcd_data_in;
   logic         t_gcd_done = 1'b0;
   logic [W-1:0] t_gcd_result = '0;

   gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
      .gcd_start(gcd_start), .gcd_data_in(gcd_data_in), .gcd_clr(gcd_clr),
      .gcd_done(gcd_done), .gcd_result(gcd_result)
   );

   gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut_to (
      .clk(clk), .rst(rst),
      .req_valid(t_req_valid), .req_ready(t_req_ready), .req_a(t_req_a), .req_b(t_req_b),
      .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_gcd(t_rsp_gcd), .rsp_err(t_rsp_err),
      .gcd_start(t_gcd_start), .gcd_data_in(t_gcd_data_in), .gcd_clr(t_gcd_clr),
      .gcd_done(t_gcd_done), .gcd_result(t_gcd_result)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return W'(x);
   endfunction

   // Behavioural subtractive engine: load A on start, B next cycle, subtract until equal.
   int           e_st = 0;
   logic [W-1:0] e_a = '0, e_b = '0;
   always @(posedge clk) begin
      if (gcd_clr) e_st <= 0;
      else case (e_st)
         0: if (gcd_start) begin e_a <= gcd_data_in; e_st <= 1; end
         1: begin e_b <= gcd_data_in; e_st <= 2; end
         2: if (e_a == e_b) e_st <= 3;
            else if (e_a > e_b) e_a <= e_a - e_b;
            else e_b <= e_b - e_a;
         default: e_st <= 3;
      endcase
   end
   assign gcd_done   = (e_st == 3);
   assign gcd_result = e_a;

   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       rsp_ready = 1'b1;
         1:       rsp_ready = 1'($urandom_range(0, 1));
         default: rsp_ready = 1'b0;
      endcase
   end

   // Scoreboard: one outstanding operand pair between acceptance and response handshake.
   typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } op_t;
   op_t          pend[$];
   int           cyc = 0, accept_cyc = 0, starts = 0;
   logic         expect_b = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_clr = 1'b0, prev_err = 1'b0;
   logic [W-1:0] prev_gcd = '0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         check("rst_ctrl", {27'd0, req_ready, rsp_valid, rsp_err, gcd_start, gcd_clr}, 32'd1);
         check("rst_data", {rsp_gcd, gcd_data_in}, 32'd0);
         pend.delete();
         expect_b   = 1'b0;
         prev_valid = 1'b0;
         prev_clr   = 1'b1;
      end else begin
         check("req_ready_idle", {31'd0, req_ready}, {31'd0, pend.size() == 0});
         if (req_ready || rsp_valid)
            check("bus_quiet", {15'd0, gcd_start, gcd_data_in}, 32'd0);
         if (rsp_valid && gcd_clr) check("clr_in_resp", 32'd1, 32'd0);
         if (gcd_start) begin
            starts++;
            if (pend.size() == 0 || pend[0].a == 0 || pend[0].b == 0)
               check("start_unexpected", 32'd1, 32'd0);
            else
               check("data_a", {16'd0, gcd_data_in}, {16'd0, pend[0].a});
            expect_b = 1'b1;
         end else if (expect_b) begin
            if (pend.size() > 0) check("data_b", {16'd0, gcd_data_in}, {16'd0, pend[0].b});
            expect_b = 1'b0;
         end
         if (prev_valid && !prev_ready) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_gcd", {15'd0, rsp_err, rsp_gcd}, {15'd0, prev_err, prev_gcd});
         end
         if (rsp_valid && !prev_valid) begin
            if (pend.size() != 1) check("rsp_without_req", pend.size(), 32'd1);
            else begin
               check("rsp_gcd_model", {15'd0, rsp_err, rsp_gcd}, {16'd0, gcd_ref(pend[0].a, pend[0].b)});
               if (pend[0].a == 0 || pend[0].b == 0) begin
                  check("zero_latency", cyc - accept_cyc, 32'd1);
                  check("zero_no_start", starts, 32'd0);
               end else begin
                  check("clr_before_rsp", {31'd0, prev_clr}, 32'd1);
                  check("one_start", starts, 32'd1);
               end
            end
         end
         if (req_valid && req_ready) begin
            pend.push_back('{a: req_a, b: req_b});
            accept_cyc = cyc;
            starts     = 0;
         end
         if (rsp_valid && rsp_ready && pend.size() > 0) void'(pend.pop_front());
         prev_valid = rsp_valid;
         prev_ready = rsp_ready;
         prev_clr   = gcd_clr;
         prev_gcd   = rsp_gcd;
         prev_err   = rsp_err;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      req_valid = 1'b1; req_a = a; req_b = b;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      if (!req_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [W-1:0] g, output logic e);
      g = '1; e = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            g = rsp_gcd; e = rsp_err;
            return;
         end
      end
      check("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic xact(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eg);
      logic [W-1:0] g;
      logic         e;
      send(a, b);
      wait_rsp(g, e);
      check(name, {15'd0, e, g}, {16'd0, eg});
   endtask

   initial begin
      logic [W-1:0] g, ra, rb;
      logic         e;
      int           n;
      logic         pclr;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_clr", {30'd0, gcd_clr, req_ready}, 32'd2);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("idle_ready", {31'd0, req_ready}, 32'd1);

      xact("gcd_48_18", 16'd48, 16'd18, 16'd6);
      xact("gcd_0_7", 16'd0, 16'd7, 16'd7);
      xact("gcd_0_0", 16'd0, 16'd0, 16'd0);
      xact("gcd_13_13", 16'd13, 16'd13, 16'd13);
      xact("gcd_35_21", 16'd35, 16'd21, 16'd7);

      // Backpressure with a pending request held off.
      rdy_mode = 2;
      send(16'd100, 16'd75);
      for (int i = 0; i < 2000 && !rsp_valid; i++) @(negedge clk);
      fork
         send(16'd12, 16'd18);
      join_none
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", {14'd0, rsp_valid, req_ready, rsp_gcd}, {14'd0, 2'b10, 16'd25});
      end
      rdy_mode = 0;
      wait_rsp(g, e);
      check("bp_first", {15'd0, e, g}, 32'd25);
      wait_rsp(g, e);
      check("bp_pending", {15'd0, e, g}, 32'd6);

      // Asynchronous reset during a long RUN.
      send(16'd1000, 16'd3);
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      check("midrun_rst", {13'd0, req_ready, rsp_valid, gcd_clr, rsp_gcd}, 32'h10000);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      xact("after_rst_20_8", 16'd20, 16'd8, 16'd4);

      rdy_mode = 1;
      for (int k = 0; k < 40; k++) begin
         ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
         xact("random", ra, rb, gcd_ref(ra, rb));
      end
      rdy_mode = 0;

      // Hung engine: 2 load cycles, 8 RUN cycles, 1 clear cycle, then RESP.
      @(posedge clk); #1;
      t_req_valid = 1'b1; t_req_a = 16'd9; t_req_b = 16'd6;
      @(negedge clk);
      check("to_ready", {31'd0, t_req_ready}, 32'd1);
      @(posedge clk); #1 t_req_valid = 1'b0;
      n = 0; pclr = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (t_rsp_valid) break;
         pclr = t_gcd_clr;
      end
      check("to_latency", n, 32'd12);
      check("to_result", {15'd0, t_rsp_err, t_rsp_gcd}, 32'h10000);
      check("to_clr", {31'd0, pclr}, 32'd1);
      @(negedge clk);
      check("to_back_idle", {30'd0, t_rsp_valid, t_req_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
